// File: rtl/fifo_arb_pkg.sv
// Shared state encoding and width helper for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Bits needed to encode 0..n-1, never less than one.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_owner, cyclically.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_owner,
    output logic             found,
    output logic [IW-1:0]    index
);

    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        // k runs 1..N_REQ so last_owner itself is checked last.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((32'(last_owner) + 32'(k)) % 32'(N_REQ));
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_last,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_WIDTH-1:0]       fifo_din,
    output logic [clog2(N_REQ)-1:0]     grant_id,
    output logic                        busy
);

    localparam int IW = clog2(N_REQ);
    localparam int BW = clog2(MAX_BURST + 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_owner_q, last_owner_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    logic [N_REQ-1:0][DATA_WIDTH-1:0] data_arr;
    logic                             pick_found;
    logic [IW-1:0]                    pick_idx;
    logic                             beat;

    assign data_arr = req_data;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req        (req_valid),
        .last_owner (last_owner_q),
        .found      (pick_found),
        .index      (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_din     = '0;
        beat         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Ready deliberately ignores req_valid to avoid a combinational loop.
                req_ready[owner_q] = !fifo_full && !rst;
                beat               = req_ready[owner_q] && req_valid[owner_q];
                fifo_wr_en         = beat;
                fifo_din           = data_arr[owner_q];
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (req_last[owner_q] || beat_cnt_d == BW'(MAX_BURST)) begin
                        state_d      = ST_IDLE;
                        last_owner_d = owner_q;
                    end
                end else if (!fifo_full && !req_valid[owner_q]) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_INIT;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign busy     = (state_q == ST_GRANT);
    assign grant_id = busy ? owner_q : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: arbitration table, directed corner sequences, randomized traffic vs model.
module tb_fifo_wr_arbiter;

    localparam int N = 4, DW = 8, MB = 4, DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            fifo_full, fifo_wr_en, busy;
    logic [DW-1:0]   fifo_din;
    logic [1:0]      grant_id;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;

    logic [8:0]   pq [N][$];    // per-producer {last, data}
    logic [DW-1:0] fq [$];      // FIFO contents
    int           wlog [$];     // owner id of each write
    int           wcyc [$];     // cycle of each write
    logic [N-1:0] en = '1;
    bit           env_on = 1'b0, rd = 1'b0;

    // Reference model: who owns the port, who owned it last, beats in this grant.
    bit m_busy = 1'b0;
    int m_owner = 0, m_prev = N - 1, m_beats = 0;

    typedef struct {
        logic [N-1:0]  valid;
        logic          full;
        logic          busy;
        logic [1:0]    gid;
        logic [N-1:0]  rdy;
        logic          wr;
        logic [DW-1:0] din;
    } vec_t;
    vec_t vt [8];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] fq_sig();
        logic [63:0] v;
        v = 64'(fq.size());
        foreach (fq[i]) v = (v << 8) | 64'(fq[i]);
        return v;
    endfunction

    function automatic logic [63:0] wsig(input int n);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v = (v << 4) | ((k < wlog.size()) ? 64'(wlog[k]) : 64'hF);
        return v;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0) begin
                req_valid[i]         = en[i];
                req_last[i]          = pq[i][0][8];
                req_data[i*DW +: DW] = pq[i][0][7:0];
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
        fifo_full = (fq.size() >= DEPTH);
    endtask

    // One clock: check outputs against the model mid-cycle, then advance model and environment.
    task automatic tick();
        logic [N-1:0]  exp_rdy, acc;
        logic          exp_wr, wr;
        logic [DW-1:0] exp_din, din;
        logic [1:0]    exp_gid;
        @(negedge clk);
        exp_rdy = '0;
        exp_din = '0;
        exp_gid = m_busy ? 2'(m_owner) : 2'd0;
        if (m_busy) begin
            exp_din = req_data[m_owner*DW +: DW];
            if (!fifo_full && !rst) exp_rdy[m_owner] = 1'b1;
        end
        exp_wr = |(exp_rdy & req_valid);
        tests++;
        if ({busy, grant_id, req_ready, fifo_wr_en, fifo_din} !== {m_busy, exp_gid, exp_rdy, exp_wr, exp_din}) begin
            fails++;
            $display("FAIL cycle %0d busy/gid/rdy/wr/din: got %b/%0d/%b/%b/%h expected %b/%0d/%b/%b/%h",
                     cyc, busy, grant_id, req_ready, fifo_wr_en, fifo_din,
                     m_busy, exp_gid, exp_rdy, exp_wr, exp_din);
        end
        acc = req_valid & req_ready;
        wr  = fifo_wr_en;
        din = fifo_din;
        if (wr) begin
            wlog.push_back(int'(grant_id));
            wcyc.push_back(cyc);
        end
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0; m_owner = 0; m_prev = N - 1; m_beats = 0;
        end else if (!m_busy) begin
            for (int j = 1; j <= N; j++) begin
                if (req_valid[(m_prev + j) % N]) begin
                    m_owner = (m_prev + j) % N; m_busy = 1'b1; m_beats = 0;
                    break;
                end
            end
        end else if (exp_wr) begin
            m_beats++;
            if (req_last[m_owner] || m_beats == MB) begin m_busy = 1'b0; m_prev = m_owner; end
        end else if (!fifo_full && !req_valid[m_owner]) begin
            m_busy = 1'b0; m_prev = m_owner;
        end
        #1;
        cyc++;
        if (rd && fq.size() > 0) void'(fq.pop_front());
        if (wr) fq.push_back(din);
        for (int i = 0; i < N; i++)
            if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        if (env_on) drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        fq.delete(); wlog.delete(); wcyc.delete();
        for (int i = 0; i < N; i++) pq[i].delete();
        en = '1; rd = 1'b0; env_on = 1'b1;
        drive();
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;

        // First grant after reset: priority starts at requester 0.
        vt[0] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        vt[1] = '{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA0};
        vt[2] = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA2};
        vt[3] = '{4'b1100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA2};
        vt[4] = '{4'b1000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 8'hA3};
        vt[5] = '{4'b1010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA1};
        vt[6] = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 8'hA0};
        vt[7] = '{4'b0110, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA1};
        for (int v = 0; v < 8; v++) begin
            env_on = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            req_valid = vt[v].valid; req_last = '0; fifo_full = vt[v].full;
            req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
            #1;
            chk($sformatf("vec%0d idle", v), 64'({busy, fifo_wr_en, req_ready}), 64'h0);
            tick();
            #1;
            chk($sformatf("vec%0d grant", v), 64'({busy, grant_id, req_ready, fifo_wr_en, fifo_din}),
                64'({vt[v].busy, vt[v].gid, vt[v].rdy, vt[v].wr, vt[v].din}));
        end

        // Single producer packet.
        do_reset();
        pq[2].push_back({1'b0, 8'hAA}); pq[2].push_back({1'b0, 8'hBB}); pq[2].push_back({1'b1, 8'hCC});
        drive(); #1;
        chk("pkt idle", 64'({busy, fifo_wr_en, req_ready}), 64'h0);
        tick(); #1; chk("pkt beat1", 64'({busy, grant_id, fifo_wr_en, fifo_din}), 64'({1'b1, 2'd2, 1'b1, 8'hAA}));
        tick(); #1; chk("pkt beat2", 64'({busy, grant_id, fifo_wr_en, fifo_din}), 64'({1'b1, 2'd2, 1'b1, 8'hBB}));
        tick(); #1; chk("pkt beat3", 64'({busy, grant_id, fifo_wr_en, fifo_din}), 64'({1'b1, 2'd2, 1'b1, 8'hCC}));
        tick(); #1; chk("pkt release", 64'(busy), 64'h0);
        chk("pkt fifo", fq_sig(), 64'h03AABBCC);
        pq[1].push_back({1'b1, 8'h11}); pq[3].push_back({1'b1, 8'h33});
        drive();
        tick(); #1; chk("pkt next after 2", 64'({busy, grant_id}), 64'({1'b1, 2'd3}));
        repeat (4) tick();

        // Round-robin fairness with 1-beat packets.
        do_reset();
        rd = 1'b1;
        for (int i = 0; i < N; i++) repeat (3) pq[i].push_back({1'b1, 8'(8'h40 + i)});
        drive();
        repeat (11) tick();
        chk("rr order", wsig(5), 64'h01230);
        chk("rr spacing", 64'((wcyc.size() >= 5) ? wcyc[4] - wcyc[0] : -1), 64'd8);

        // Burst limit.
        do_reset();
        rd = 1'b1;
        for (int k = 0; k < 6; k++) pq[1].push_back({1'b0, 8'(8'h50 + k)});
        pq[3].push_back({1'b1, 8'h3F});
        drive();
        repeat (16) tick();
        chk("burst order", wsig(8), 64'h1111311F);

        // Full backpressure.
        do_reset();
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
        pq[0].push_back({1'b0, 8'hA1}); pq[0].push_back({1'b0, 8'hA2}); pq[0].push_back({1'b1, 8'hA3});
        drive();
        tick(); #1; chk("bp beat1", 64'({busy, fifo_wr_en, fifo_din}), 64'({1'b1, 1'b1, 8'hA1}));
        tick(); #1; chk("bp stall", 64'({fifo_full, req_ready, fifo_wr_en, busy}), 64'({1'b1, 4'b0000, 1'b0, 1'b1}));
        tick(); tick(); #1;
        chk("bp held", 64'({busy, grant_id, fifo_wr_en, req_ready}), 64'({1'b1, 2'd0, 1'b0, 4'b0000}));
        rd = 1'b1;
        tick(); tick();
        rd = 1'b0;
        repeat (4) tick();
        chk("bp fifo", fq_sig(), 64'h0433A1A2A3);

        // Owner goes idle without last.
        do_reset();
        rd = 1'b1;
        pq[0].push_back({1'b0, 8'h01}); pq[0].push_back({1'b0, 8'h02});
        pq[2].push_back({1'b1, 8'h2C});
        drive();
        tick(); #1; chk("idle beat", 64'({busy, grant_id, fifo_wr_en, fifo_din}), 64'({1'b1, 2'd0, 1'b1, 8'h01}));
        en[0] = 1'b0; drive(); #1;
        chk("idle drop", 64'({busy, fifo_wr_en, req_ready}), 64'({1'b1, 1'b0, 4'b0001}));
        tick(); #1; chk("idle released", 64'(busy), 64'h0);
        tick(); #1; chk("idle grant2", 64'({busy, grant_id, fifo_wr_en, fifo_din}), 64'({1'b1, 2'd2, 1'b1, 8'h2C}));
        wlog.delete(); wcyc.delete();
        en[0] = 1'b1;
        for (int k = 3; k < 7; k++) pq[0].push_back({1'b0, 8'(k)});
        drive();
        repeat (12) tick();
        chk("idle next order", wsig(6), 64'h200000);
        chk("idle burst restart", 64'((wcyc.size() >= 5) ? wcyc[4] - wcyc[1] : -1), 64'd3);

        // Reset in the middle of a burst.
        do_reset();
        rd = 1'b1;
        for (int k = 1; k <= 4; k++) pq[3].push_back({k == 4, 8'(8'h30 + k)});
        drive();
        tick(); tick();
        rst = 1'b1; #1;
        chk("rst forced", 64'({fifo_wr_en, req_ready}), 64'h0);
        tick();
        rst = 1'b0; #1;
        chk("rst values", 64'({busy, grant_id, req_ready, fifo_wr_en, fifo_din}), 64'h0);
        pq[0].push_back({1'b1, 8'h0A});
        drive();
        tick(); #1; chk("rst next grant", 64'({busy, grant_id}), 64'({1'b1, 2'd0}));
        repeat (8) tick();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pq[i].size() < 3 && $urandom_range(0, 3) == 0) begin
                    int len;
                    bit tail;
                    len  = int'($urandom_range(1, 6));
                    tail = ($urandom_range(0, 3) != 0);
                    for (int k = 0; k < len; k++)
                        pq[i].push_back({tail && (k == len - 1), 8'($urandom)});
                end
                en[i] = ($urandom_range(0, 4) != 0);
            end
            rd  = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            drive();
            tick();
        end
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
